harq_send_llr_reader: RTL and testbench
=======================================

Name: harq_send_llr_reader

Overview:
- Downstream consumer of the combine stage's ping/pong LLR buffers; it serves the SENDHARQ request/busy/comp handshake on both buffers.
- For each request it reads the combined 160-bit words (16 x 10-bit signed LLRs) through the shared read-address port.
- Each LLR is saturated to 8 bits and the words are streamed over a valid/ready interface to the HARQ memory writer.
- The stream carries per-LLR keep and last markers.

Parameters:
- ADDR_WIDTH, 11, buffer word-address width; maximum 2^ADDR_WIDTH words per code block.
- LLR_IN_W, 10, combined LLR width at the buffer output.
- LLR_OUT_W, 8, saturated LLR width on the output stream.
- LANES, 16, LLRs per buffer word.

Ports:
- i_core_clk  in  1  core clock.
- i_rx_rst  in  1  reset, synchronous, active-high.
- i_SENDHARQ_Data_Ping_request  in  1  ping buffer holds a complete code block.
- i_SENDHARQ_Data_Pong_request  in  1  pong buffer holds a complete code block.
- i_SENDHARQ_Data_Ping_Add_Amount  in  16  LLR count to send from ping; sampled on acceptance.
- i_SENDHARQ_Data_Pong_Add_Amount  in  16  LLR count to send from pong; sampled on acceptance.
- o_SENDHARQ_Data_Ping_Comp  out  1  one-cycle pulse when ping transfer finishes.
- o_SENDHARQ_Data_Pong_Comp  out  1  one-cycle pulse when pong transfer finishes.
- o_SENDHARQ_Data_Ping_Busy  out  1  ping buffer is owned by this block.
- o_SENDHARQ_Data_Pong_Busy  out  1  pong buffer is owned by this block.
- o_SENDHARQ_Data_Address  out  ADDR_WIDTH  read address to both buffers.
- i_Ping_Buffer_Read_Data  in  160  ping buffer q; registered, 1-cycle read latency.
- i_Pong_Buffer_Read_Data  in  160  pong buffer q; registered, 1-cycle read latency.
- o_HARQ_Data_Valid  out  1  output word valid.
- i_HARQ_Data_Ready  in  1  downstream accepts the word.
- o_HARQ_Data  out  128  16 x 8-bit saturated LLRs; lane 0 in bits [7:0].
- o_HARQ_Data_Keep  out  16  per-lane valid mask.
- o_HARQ_Data_Last  out  1  final word of the code block.
- o_HARQ_Buf_Sel  out  1  source buffer of the current word; 0 = ping, 1 = pong.

Behaviour:
- Reset (i_rx_rst = 1 at a clock edge), including mid-transfer:
  - All outputs return to 0 and the FSM goes to IDLE.
  - The FIFO is flushed, in-flight reads are discarded and next_buf is set to 0.
  - No Comp pulse is issued for an aborted transfer.
- Busy: Ping_Busy = Ping_request OR (serving ping); Pong_Busy likewise. Busy may stay high for one cycle after Comp; this is intentional and conservative.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - If the next_buf request is high, accept it.
  - Otherwise accept the other buffer's request if it is high.
  - On acceptance: latch buf_sel and amount; words = ceil(amount / 16), clamped to 2^ADDR_WIDTH; tail = amount mod 16 (0 means full).
  - Address resets to 0. Go to READ, or to DONE if amount = 0.
- READ:
  - Issue address a when FIFO occupancy plus in-flight reads < 2.
  - Data returns one cycle later and is pushed into the 2-entry FIFO.
  - After the last address is issued, go to DRAIN.
- DRAIN: wait until the last read returns and the FIFO is empty (last word accepted), then go to DONE.
- DONE:
  - Pulse Comp for buf_sel for one cycle and toggle next_buf.
  - Go to IDLE.
  - A request still high in the following cycle (the upstream clears it one cycle after Comp) is not re-accepted: acceptance also requires that the same buffer did not complete in the previous cycle.
- Saturation per lane: signed 10-bit value clamped to [-127, +127]; -128 to -512 map to -127.
- Keep: all ones, except the last word when tail != 0, where keep = (1 << tail) - 1. Lanes with keep = 0 are driven with zero data.
- Output rules:
  - Last is high only on the final word.
  - Valid, data, keep, last and buf_sel are held stable while valid && !ready.
  - Throughput is 1 word per cycle under continuous ready.
- Latency: the first o_HARQ_Data_Valid arrives 3 cycles after the request is seen high in IDLE (accept, address, data).
- Address output holds its last value when idle.

Decomposition:
- Package harq_send_pkg: state enum; LANES, LLR_IN_W and LLR_OUT_W constants; saturation limit constant (127); a sat10to8 function.
- Sub-module harq_send_fifo2: 2-entry synchronous FIFO of 128 + 16 + 1 + 1 bits with push/pop/full/empty, reset by i_rx_rst.

Test Plan:
- Ping request, amount 160, ready = 1:
  - Addresses 0..9 appear on consecutive cycles.
  - 10 words are output; the last has keep = 0xFFFF and last = 1.
  - One Ping_Comp pulse; Pong_Busy stays 0.
- Pong request, amount 37:
  - 3 words are output; the last has keep = 0x001F.
  - Lanes with keep = 0 read 0x00.
  - Pong_Comp pulses once.
- Lane values +300, -300, +127, -128, 5 -> output 0x7F, 0x81, 0x7F, 0x81, 0x05.
- Amount 64 with ready toggling 1,0,0,1,...:
  - No word is lost or duplicated; data is stable while stalled.
  - FIFO never overflows; 4 words delivered in order.
- Both requests high after reset -> ping is served first, then pong; second Comp follows first; no re-acceptance of ping from its stale request.
- Assert i_rx_rst during word 5 of a 20-word transfer:
  - Next cycle all outputs are 0 and no Comp is issued.
  - A fresh ping request afterwards restarts at address 0.
- Amount 0: Comp pulses within 2 cycles of acceptance with no valid output.

Source files
------------

// File: rtl/harq_send_pkg.sv
// Shared types and constants for the SENDHARQ LLR reader: FSM states, lane geometry
// and the 10-to-8 bit LLR saturation helper.
package harq_send_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int LANES     = 16;
    localparam int LLR_IN_W  = 10;
    localparam int LLR_OUT_W = 8;
    localparam int SAT_LIMIT = 127;

    // FIFO payload: {last, buf_sel, keep[LANES-1:0], data[LANES*LLR_OUT_W-1:0]}
    localparam int PAYLOAD_W = LANES * LLR_OUT_W + LANES + 2;

    // Symmetric clamp to [-127, +127] so -128 never reaches the HARQ memory.
    function automatic logic [LLR_OUT_W-1:0] sat10to8(input logic signed [LLR_IN_W-1:0] v);
        logic signed [LLR_IN_W-1:0] hi;
        logic signed [LLR_IN_W-1:0] lo;
        logic [LLR_OUT_W-1:0]       r;
        hi = LLR_IN_W'(SAT_LIMIT);
        lo = -hi;
        if (v > hi) begin
            r = LLR_OUT_W'(SAT_LIMIT);
        end else if (v < lo) begin
            r = LLR_OUT_W'(-SAT_LIMIT);
        end else begin
            r = v[LLR_OUT_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/harq_send_fifo2.sv
// Two-entry synchronous FIFO holding formatted output words between the buffer
// read pipeline and the valid/ready stream.
module harq_send_fifo2
    import harq_send_pkg::*;
#(
    parameter int WIDTH = PAYLOAD_W
) (
    input  logic             i_core_clk,
    input  logic             i_rx_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && (r_count != 2'd0);
    assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
        end
    end

    always_ff @(posedge i_core_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/harq_send_llr_reader.sv
// Serves SENDHARQ ping/pong requests: reads combined LLR words from the selected
// buffer, saturates them to 8 bits and streams them with keep/last markers.
module harq_send_llr_reader
    import harq_send_pkg::*;
#(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                        i_core_clk,
    input  logic                        i_rx_rst,
    input  logic                        i_SENDHARQ_Data_Ping_request,
    input  logic                        i_SENDHARQ_Data_Pong_request,
    input  logic [15:0]                 i_SENDHARQ_Data_Ping_Add_Amount,
    input  logic [15:0]                 i_SENDHARQ_Data_Pong_Add_Amount,
    output logic                        o_SENDHARQ_Data_Ping_Comp,
    output logic                        o_SENDHARQ_Data_Pong_Comp,
    output logic                        o_SENDHARQ_Data_Ping_Busy,
    output logic                        o_SENDHARQ_Data_Pong_Busy,
    output logic [ADDR_WIDTH-1:0]       o_SENDHARQ_Data_Address,
    input  logic [LANES*LLR_IN_W-1:0]   i_Ping_Buffer_Read_Data,
    input  logic [LANES*LLR_IN_W-1:0]   i_Pong_Buffer_Read_Data,
    output logic                        o_HARQ_Data_Valid,
    input  logic                        i_HARQ_Data_Ready,
    output logic [LANES*LLR_OUT_W-1:0]  o_HARQ_Data,
    output logic [LANES-1:0]            o_HARQ_Data_Keep,
    output logic                        o_HARQ_Data_Last,
    output logic                        o_HARQ_Buf_Sel
);

    localparam int          DATA_W    = LANES * LLR_OUT_W;
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_buf_sel;
    logic                    r_next_buf;
    logic [ADDR_WIDTH-1:0]   r_last_addr;
    logic [3:0]              r_tail;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_inflight;
    logic                    r_inflight_last;
    logic                    r_prev_comp_ping;
    logic                    r_prev_comp_pong;

    logic                    w_ping_ok;
    logic                    w_pong_ok;
    logic                    w_accept_ok;
    logic                    w_accept_sel;
    logic                    w_accept;
    logic [15:0]             w_amount;
    logic [16:0]             w_words_raw;
    logic [16:0]             w_words;
    logic                    w_issue;
    logic                    w_ping_comp;
    logic                    w_pong_comp;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_pop;
    logic [1:0]              w_fifo_count;
    logic [2:0]              w_load;
    logic [LANES-1:0]        w_keep;
    logic [LANES*LLR_IN_W-1:0] w_src;
    logic [DATA_W-1:0]       w_lanes;
    logic [PAYLOAD_W-1:0]    w_push_data;
    logic [PAYLOAD_W-1:0]    w_head;

    // A request that just completed is still high for one cycle and must not restart.
    assign w_ping_ok = i_SENDHARQ_Data_Ping_request && !r_prev_comp_ping;
    assign w_pong_ok = i_SENDHARQ_Data_Pong_request && !r_prev_comp_pong;

    always_comb begin
        w_accept_ok  = 1'b0;
        w_accept_sel = r_next_buf;
        if (r_next_buf ? w_pong_ok : w_ping_ok) begin
            w_accept_ok = 1'b1;
        end else if (r_next_buf ? w_ping_ok : w_pong_ok) begin
            w_accept_ok  = 1'b1;
            w_accept_sel = ~r_next_buf;
        end
    end

    assign w_amount    = w_accept_sel ? i_SENDHARQ_Data_Pong_Add_Amount : i_SENDHARQ_Data_Ping_Add_Amount;
    assign w_words_raw = ({1'b0, w_amount} + 17'd15) >> 4;
    assign w_words     = (w_words_raw > MAX_WORDS) ? MAX_WORDS : w_words_raw;

    // Occupancy counts the head leaving this cycle so reads can issue every cycle.
    assign w_pop        = !w_empty && i_HARQ_Data_Ready;
    assign w_fifo_count = w_full ? 2'd2 : (w_empty ? 2'd0 : 2'd1);
    assign w_load       = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_issue      = 1'b0;
        w_ping_comp  = 1'b0;
        w_pong_comp  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept_ok) begin
                    w_accept     = 1'b1;
                    w_next_state = (w_amount == 16'd0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                w_issue = (w_load < 3'd2);
                if (w_issue && (r_addr == r_last_addr)) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!r_inflight && w_empty) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_ping_comp  = !r_buf_sel;
                w_pong_comp  = r_buf_sel;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            r_state          <= ST_IDLE;
            r_buf_sel        <= 1'b0;
            r_next_buf       <= 1'b0;
            r_last_addr      <= '0;
            r_tail           <= 4'd0;
            r_addr           <= '0;
            r_inflight       <= 1'b0;
            r_inflight_last  <= 1'b0;
            r_prev_comp_ping <= 1'b0;
            r_prev_comp_pong <= 1'b0;
        end else begin
            r_state          <= w_next_state;
            r_prev_comp_ping <= w_ping_comp;
            r_prev_comp_pong <= w_pong_comp;
            r_inflight       <= w_issue;
            r_inflight_last  <= w_issue && (r_addr == r_last_addr);
            if (w_accept) begin
                r_buf_sel   <= w_accept_sel;
                r_tail      <= w_amount[3:0];
                r_last_addr <= ADDR_WIDTH'(w_words - 17'd1);
                r_addr      <= '0;
            end else if (w_issue && (r_addr != r_last_addr)) begin
                r_addr <= r_addr + 1'b1;
            end
            if (r_state == ST_DONE) begin
                r_next_buf <= ~r_next_buf;
            end
        end
    end

    // Format the returning word; lanes beyond the tail are zeroed, not just masked.
    always_comb begin
        w_keep = '1;
        if (r_inflight_last && (r_tail != 4'd0)) begin
            w_keep = LANES'((32'd1 << r_tail) - 32'd1);
        end
        w_src   = r_buf_sel ? i_Pong_Buffer_Read_Data : i_Ping_Buffer_Read_Data;
        w_lanes = '0;
        for (int i = 0; i < LANES; i++) begin
            if (w_keep[i]) begin
                w_lanes[i*LLR_OUT_W +: LLR_OUT_W] = sat10to8(w_src[i*LLR_IN_W +: LLR_IN_W]);
            end
        end
    end

    assign w_push_data = {r_inflight_last, r_buf_sel, w_keep, w_lanes};

    harq_send_fifo2 #(
        .WIDTH (PAYLOAD_W)
    ) u_fifo (
        .i_core_clk (i_core_clk),
        .i_rx_rst   (i_rx_rst),
        .i_push     (r_inflight),
        .i_data     (w_push_data),
        .i_pop      (w_pop),
        .o_data     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign o_HARQ_Data_Valid = !w_empty;
    assign o_HARQ_Data       = w_empty ? '0 : w_head[DATA_W-1:0];
    assign o_HARQ_Data_Keep  = w_empty ? '0 : w_head[DATA_W +: LANES];
    assign o_HARQ_Buf_Sel    = !w_empty && w_head[DATA_W+LANES];
    assign o_HARQ_Data_Last  = !w_empty && w_head[DATA_W+LANES+1];

    assign o_SENDHARQ_Data_Address   = r_addr;
    assign o_SENDHARQ_Data_Ping_Comp = w_ping_comp;
    assign o_SENDHARQ_Data_Pong_Comp = w_pong_comp;
    assign o_SENDHARQ_Data_Ping_Busy = i_SENDHARQ_Data_Ping_request || ((r_state != ST_IDLE) && !r_buf_sel);
    assign o_SENDHARQ_Data_Pong_Busy = i_SENDHARQ_Data_Pong_request || ((r_state != ST_IDLE) && r_buf_sel);

endmodule

// File: tb/tb_harq_send_llr_reader.sv
// Scoreboard bench for harq_send_llr_reader: models the ping/pong buffers and the
// upstream request behaviour, and checks the formatted stream and handshake pulses.
module tb_harq_send_llr_reader;

    typedef struct packed {
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
        logic         sel;
    } word_t;

    logic         clk;
    logic         rst;
    logic         ping_req;
    logic         pong_req;
    logic [15:0]  ping_amt;
    logic [15:0]  pong_amt;
    logic         ping_comp;
    logic         pong_comp;
    logic         ping_busy;
    logic         pong_busy;
    logic [10:0]  addr;
    logic [159:0] ping_q;
    logic [159:0] pong_q;
    logic         valid;
    logic         ready;
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
    logic         bsel;

    logic [159:0] ping_mem [2048];
    logic [159:0] pong_mem [2048];

    word_t exp_q [$];
    word_t rcv_q [$];
    int    addr_q [$];
    int    ping_comp_at [$];
    int    pong_comp_at [$];
    int    first_valid;
    int    stable_err;
    bit    pong_busy_seen;
    int    total;
    int    bad;

    harq_send_llr_reader #(
        .ADDR_WIDTH (11)
    ) dut (
        .i_core_clk                      (clk),
        .i_rx_rst                        (rst),
        .i_SENDHARQ_Data_Ping_request    (ping_req),
        .i_SENDHARQ_Data_Pong_request    (pong_req),
        .i_SENDHARQ_Data_Ping_Add_Amount (ping_amt),
        .i_SENDHARQ_Data_Pong_Add_Amount (pong_amt),
        .o_SENDHARQ_Data_Ping_Comp       (ping_comp),
        .o_SENDHARQ_Data_Pong_Comp       (pong_comp),
        .o_SENDHARQ_Data_Ping_Busy       (ping_busy),
        .o_SENDHARQ_Data_Pong_Busy       (pong_busy),
        .o_SENDHARQ_Data_Address         (addr),
        .i_Ping_Buffer_Read_Data         (ping_q),
        .i_Pong_Buffer_Read_Data         (pong_q),
        .o_HARQ_Data_Valid               (valid),
        .i_HARQ_Data_Ready               (ready),
        .o_HARQ_Data                     (data),
        .o_HARQ_Data_Keep                (keep),
        .o_HARQ_Data_Last                (last),
        .o_HARQ_Buf_Sel                  (bsel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffers have a registered 1-cycle read latency
    always @(posedge clk) begin
        ping_q <= ping_mem[addr];
        pong_q <= pong_mem[addr];
    end

    function automatic logic [9:0] llr_pat(input int sel, input int w, input int l);
        int v;
        v = ((w * 16 + l) * 37 + sel * 211) % 1024 - 512;
        return 10'(v);
    endfunction

    function automatic logic [7:0] exp_sat(input int v);
        if (v > 127) return 8'h7F;
        if (v < -127) return 8'h81;
        return 8'(v);
    endfunction

    task automatic push_expected(input bit sel, input int amount);
        int words;
        int tail;
        word_t e;
        logic [159:0] row;
        logic signed [9:0] s;
        bit k;
        words = (amount + 15) / 16;
        tail  = amount % 16;
        for (int w = 0; w < words; w++) begin
            row    = sel ? pong_mem[w] : ping_mem[w];
            e      = '0;
            e.last = (w == words - 1);
            e.sel  = sel;
            for (int l = 0; l < 16; l++) begin
                k         = (w < words - 1) || (tail == 0) || (l < tail);
                s         = row[l*10 +: 10];
                e.keep[l] = k;
                if (k) e.data[l*8 +: 8] = exp_sat(int'(s));
            end
            exp_q.push_back(e);
        end
    endtask

    // Runs the stream for ncyc cycles acting as upstream (drops a request two cycles
    // after its Comp) and as downstream (ready always, or 1,0,0 repeating).
    task automatic collect(input int ncyc, input bit stall);
        word_t cur;
        word_t prev;
        bit    stalled;
        int    ping_drop;
        int    pong_drop;
        rcv_q.delete();
        addr_q.delete();
        ping_comp_at.delete();
        pong_comp_at.delete();
        first_valid    = -1;
        stable_err     = 0;
        pong_busy_seen = 0;
        stalled        = 0;
        prev           = '0;
        ping_drop      = -1;
        pong_drop      = -1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (c == ping_drop) ping_req = 1'b0;
            if (c == pong_drop) pong_req = 1'b0;
            ready = stall ? (c % 3 == 0) : 1'b1;
            cur   = {data, keep, last, bsel};
            if (stalled && (cur !== prev)) stable_err++;
            addr_q.push_back(int'(addr));
            if (ping_comp) begin ping_comp_at.push_back(c); ping_drop = c + 2; end
            if (pong_comp) begin pong_comp_at.push_back(c); pong_drop = c + 2; end
            if (pong_busy) pong_busy_seen = 1;
            if (valid && first_valid < 0) first_valid = c;
            if (valid && ready) rcv_q.push_back(cur);
            stalled = valid && !ready;
            prev    = cur;
        end
        ready = 1'b1;
    endtask

    task automatic test_reset();
        logic [164:0] outs;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        outs = {valid, data, keep, last, bsel, ping_comp, pong_comp, ping_busy, pong_busy, addr};
        total++;
        if (outs !== '0) begin bad++; $display("[TB] FAIL reset_hold: got %h want 0", outs); end
        rst = 1'b0;
        @(negedge clk);
        outs = {valid, data, keep, last, bsel, ping_comp, pong_comp, ping_busy, pong_busy, addr};
        total++;
        if (outs !== '0) begin bad++; $display("[TB] FAIL reset_release: got %h want 0", outs); end
    endtask

    task automatic test_ping_full();
        word_t e, r;
        int n;
        push_expected(1'b0, 160);
        ping_amt = 16'd160;
        ping_req = 1'b1;
        collect(30, 1'b0);
        for (int i = 0; i < 10; i++) begin
            total++;
            if (addr_q[i] !== i) begin bad++; $display("[TB] FAIL ping160_addr%0d: got %0d want %0d", i, addr_q[i], i); end
        end
        total++;
        if (first_valid !== 2) begin bad++; $display("[TB] FAIL ping160_latency: got %0d want 2", first_valid); end
        n = rcv_q.size();
        total++;
        if (n !== 10) begin bad++; $display("[TB] FAIL ping160_count: got %0d want 10", n); end
        while (exp_q.size() > 0 && rcv_q.size() > 0) begin
            e = exp_q.pop_front();
            r = rcv_q.pop_front();
            total++;
            if (r !== e) begin bad++; $display("[TB] FAIL ping160_word: got %h want %h", r, e); end
        end
        total++;
        if (ping_comp_at.size() !== 1) begin bad++; $display("[TB] FAIL ping160_comp: got %0d pulses want 1", ping_comp_at.size()); end
        total++;
        if (pong_busy_seen !== 1'b0) begin bad++; $display("[TB] FAIL ping160_pong_busy: got %0b want 0", pong_busy_seen); end
        exp_q.delete();
    endtask

    task automatic test_pong_partial();
        word_t e, r;
        push_expected(1'b1, 37);
        pong_amt = 16'd37;
        pong_req = 1'b1;
        collect(20, 1'b0);
        total++;
        if (rcv_q.size() !== 3) begin bad++; $display("[TB] FAIL pong37_count: got %0d want 3", rcv_q.size()); end
        if (rcv_q.size() == 3) begin
            total++;
            if (rcv_q[2].keep !== 16'h001F) begin bad++; $display("[TB] FAIL pong37_keep: got %h want 001f", rcv_q[2].keep); end
            total++;
            if (rcv_q[2].data[127:40] !== '0) begin bad++; $display("[TB] FAIL pong37_zero_lanes: got %h want 0", rcv_q[2].data[127:40]); end
        end
        while (exp_q.size() > 0 && rcv_q.size() > 0) begin
            e = exp_q.pop_front();
            r = rcv_q.pop_front();
            total++;
            if (r !== e) begin bad++; $display("[TB] FAIL pong37_word: got %h want %h", r, e); end
        end
        total++;
        if (pong_comp_at.size() !== 1) begin bad++; $display("[TB] FAIL pong37_comp: got %0d pulses want 1", pong_comp_at.size()); end
        exp_q.delete();
    endtask

    task automatic test_saturation();
        word_t e, r;
        logic [39:0] want;
        ping_mem[0][9:0]   = 10'(300);
        ping_mem[0][19:10] = 10'(-300);
        ping_mem[0][29:20] = 10'(127);
        ping_mem[0][39:30] = 10'(-128);
        ping_mem[0][49:40] = 10'(5);
        ping_mem[0][59:50] = 10'(-512);
        ping_mem[0][69:60] = 10'(511);
        ping_mem[0][79:70] = 10'(-127);
        want = {8'h05, 8'h81, 8'h7F, 8'h81, 8'h7F};
        push_expected(1'b0, 16);
        ping_amt = 16'd16;
        ping_req = 1'b1;
        collect(12, 1'b0);
        total++;
        if (rcv_q.size() !== 1) begin bad++; $display("[TB] FAIL sat_count: got %0d want 1", rcv_q.size()); end
        if (rcv_q.size() > 0) begin
            total++;
            if (rcv_q[0].data[39:0] !== want) begin bad++; $display("[TB] FAIL sat_lanes: got %h want %h", rcv_q[0].data[39:0], want); end
        end
        while (exp_q.size() > 0 && rcv_q.size() > 0) begin
            e = exp_q.pop_front();
            r = rcv_q.pop_front();
            total++;
            if (r !== e) begin bad++; $display("[TB] FAIL sat_word: got %h want %h", r, e); end
        end
        exp_q.delete();
    endtask

    task automatic test_stall();
        word_t e, r;
        push_expected(1'b0, 64);
        ping_amt = 16'd64;
        ping_req = 1'b1;
        collect(40, 1'b1);
        total++;
        if (rcv_q.size() !== 4) begin bad++; $display("[TB] FAIL stall_count: got %0d want 4", rcv_q.size()); end
        total++;
        if (stable_err !== 0) begin bad++; $display("[TB] FAIL stall_stable: got %0d changes want 0", stable_err); end
        while (exp_q.size() > 0 && rcv_q.size() > 0) begin
            e = exp_q.pop_front();
            r = rcv_q.pop_front();
            total++;
            if (r !== e) begin bad++; $display("[TB] FAIL stall_word: got %h want %h", r, e); end
        end
        total++;
        if (ping_comp_at.size() !== 1) begin bad++; $display("[TB] FAIL stall_comp: got %0d pulses want 1", ping_comp_at.size()); end
        exp_q.delete();
    endtask

    task automatic test_both_requests();
        word_t e, r;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push_expected(1'b0, 48);
        push_expected(1'b1, 32);
        ping_amt = 16'd48;
        pong_amt = 16'd32;
        ping_req = 1'b1;
        pong_req = 1'b1;
        collect(40, 1'b0);
        total++;
        if (rcv_q.size() !== 5) begin bad++; $display("[TB] FAIL both_count: got %0d want 5", rcv_q.size()); end
        while (exp_q.size() > 0 && rcv_q.size() > 0) begin
            e = exp_q.pop_front();
            r = rcv_q.pop_front();
            total++;
            if (r !== e) begin bad++; $display("[TB] FAIL both_word: got %h want %h", r, e); end
        end
        total++;
        if (ping_comp_at.size() !== 1 || pong_comp_at.size() !== 1) begin
            bad++;
            $display("[TB] FAIL both_comp_count: got ping=%0d pong=%0d want 1 and 1", ping_comp_at.size(), pong_comp_at.size());
        end else begin
            total++;
            if (pong_comp_at[0] <= ping_comp_at[0]) begin
                bad++;
                $display("[TB] FAIL both_comp_order: got pong@%0d ping@%0d want pong after ping", pong_comp_at[0], ping_comp_at[0]);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_midreset();
        word_t e, r;
        int hs;
        logic [164:0] outs;
        int comps;
        hs       = 0;
        ping_amt = 16'd320;
        ping_req = 1'b1;
        for (int c = 0; c < 60 && hs < 5; c++) begin
            @(negedge clk);
            ready = 1'b1;
            if (valid && ready) hs++;
        end
        total++;
        if (hs !== 5) begin bad++; $display("[TB] FAIL midrst_reach_word5: got %0d words want 5", hs); end
        rst      = 1'b1;
        ping_req = 1'b0;
        @(negedge clk);
        outs = {valid, data, keep, last, bsel, ping_comp, pong_comp, ping_busy, pong_busy, addr};
        total++;
        if (outs !== '0) begin bad++; $display("[TB] FAIL midrst_outputs: got %h want 0", outs); end
        rst   = 1'b0;
        comps = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ping_comp || pong_comp || valid) comps++;
        end
        total++;
        if (comps !== 0) begin bad++; $display("[TB] FAIL midrst_no_comp: got %0d active cycles want 0", comps); end
        push_expected(1'b0, 32);
        ping_amt = 16'd32;
        ping_req = 1'b1;
        collect(15, 1'b0);
        total++;
        if (addr_q[0] !== 0) begin bad++; $display("[TB] FAIL midrst_restart_addr: got %0d want 0", addr_q[0]); end
        total++;
        if (rcv_q.size() !== 2) begin bad++; $display("[TB] FAIL midrst_count: got %0d want 2", rcv_q.size()); end
        while (exp_q.size() > 0 && rcv_q.size() > 0) begin
            e = exp_q.pop_front();
            r = rcv_q.pop_front();
            total++;
            if (r !== e) begin bad++; $display("[TB] FAIL midrst_word: got %h want %h", r, e); end
        end
        exp_q.delete();
    endtask

    task automatic test_zero_amount();
        ping_amt = 16'd0;
        ping_req = 1'b1;
        collect(10, 1'b0);
        total++;
        if (ping_comp_at.size() !== 1) begin
            bad++;
            $display("[TB] FAIL zero_comp_count: got %0d want 1", ping_comp_at.size());
        end else begin
            total++;
            if (ping_comp_at[0] > 1) begin bad++; $display("[TB] FAIL zero_comp_time: got cycle %0d want <=1", ping_comp_at[0]); end
        end
        total++;
        if (first_valid !== -1) begin bad++; $display("[TB] FAIL zero_no_valid: got valid at %0d want none", first_valid); end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        ready    = 1'b1;
        ping_req = 1'b0;
        pong_req = 1'b0;
        ping_amt = 16'd0;
        pong_amt = 16'd0;
        for (int w = 0; w < 2048; w++) begin
            for (int l = 0; l < 16; l++) begin
                ping_mem[w][l*10 +: 10] = llr_pat(0, w, l);
                pong_mem[w][l*10 +: 10] = llr_pat(1, w, l);
            end
        end
        @(negedge clk);
        test_reset();
        test_ping_full();
        test_pong_partial();
        test_saturation();
        test_stall();
        test_both_requests();
        test_midreset();
        test_zero_amount();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
